// File: rtl/poly8_sweep.sv
// Sweeps idx = base..base+count-1 through a pipelined poly8 callee, summing the returns mod 2^32.
// One issue and one return per cycle at most, up to MAX_OUT calls in flight; the host result holds while stall=1.
module poly8_sweep #(
    parameter int MAX_OUT = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    input  logic [31:0] base,
    input  logic [15:0] count,
    output logic        done,
    input  logic        stall,
    output logic [31:0] returndata,
    output logic        k_start,
    input  logic        k_busy,
    output logic [31:0] k_idx,
    input  logic        k_done,
    output logic        k_stall,
    input  logic [31:0] k_returndata
);

    localparam logic [3:0] MAX_OUT_W = 4'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESULT} state_t;

    state_t      state;
    logic [31:0] base_q;
    logic [31:0] sum;
    logic [15:0] count_q;
    logic [15:0] issued;
    logic [15:0] received;
    logic [3:0]  outstanding;

    logic        issue;
    logic        accept;
    logic [15:0] issued_nx;
    logic [15:0] received_nx;

    assign busy       = (state != IDLE);
    assign done       = (state == RESULT);
    assign returndata = (state == RESULT) ? sum : 32'd0;
    assign k_stall    = !((state == RUN) || (state == DRAIN));
    assign k_start    = (state == RUN) && (issued < count_q) && (outstanding < MAX_OUT_W);
    assign k_idx      = base_q + {16'd0, issued};

    assign issue       = k_start && !k_busy;
    assign accept      = k_done && !k_stall;
    assign issued_nx   = issued + {15'd0, issue};
    assign received_nx = received + {15'd0, accept};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            base_q      <= 32'd0;
            count_q     <= 16'd0;
            sum         <= 32'd0;
            issued      <= 16'd0;
            received    <= 16'd0;
            outstanding <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q      <= base;
                        count_q     <= count;
                        sum         <= 32'd0;
                        issued      <= 16'd0;
                        received    <= 16'd0;
                        outstanding <= 4'd0;
                        state       <= (count == 16'd0) ? RESULT : RUN;
                    end
                end
                RUN, DRAIN: begin
                    issued      <= issued_nx;
                    received    <= received_nx;
                    outstanding <= outstanding + {3'd0, issue} - {3'd0, accept};
                    if (accept) begin
                        sum <= sum + k_returndata;
                    end
                    // received can only reach count once issued has, so this also covers RUN -> RESULT
                    if (received_nx == count_q) begin
                        state <= RESULT;
                    end else if (issued_nx == count_q) begin
                        state <= DRAIN;
                    end
                end
                RESULT: begin
                    if (!stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly8_sweep.sv
// Directed and randomized sweeps against a queue-based poly8 model (returns 2*idx after lat cycles).
module tb_poly8_sweep;

    localparam int MAX_OUT = 4;

    logic        clock;
    logic        resetn;
    logic        start;
    logic        busy;
    logic [31:0] base;
    logic [15:0] count;
    logic        done;
    logic        stall;
    logic [31:0] returndata;
    logic        k_start;
    logic        k_busy;
    logic [31:0] k_idx;
    logic        k_done;
    logic        k_stall;
    logic [31:0] k_returndata;

    poly8_sweep #(.MAX_OUT(MAX_OUT)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start),
        .busy         (busy),
        .base         (base),
        .count        (count),
        .done         (done),
        .stall        (stall),
        .returndata   (returndata),
        .k_start      (k_start),
        .k_busy       (k_busy),
        .k_idx        (k_idx),
        .k_done       (k_done),
        .k_stall      (k_stall),
        .k_returndata (k_returndata)
    );

    int checks = 0;
    int errors = 0;

    // model state
    int          cyc = 0;
    int          lat = 3;
    bit          rand_busy = 0;
    bit          busy_arm = 0;
    int          bk_cnt = 0;
    bit          stale_mode = 0;
    bit          prev_stalled = 0;
    logic [31:0] prev_idx = 32'd0;
    int          max_out_seen = 0;
    logic [31:0] pend_idx[$];
    int          pend_due[$];
    logic [31:0] iss_log[$];
    int          iss_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // poly8 callee model: all decisions made on the falling edge for the next rising edge
    initial begin
        k_busy       = 1'b0;
        k_done       = 1'b0;
        k_returndata = 32'd0;
        forever begin
            @(negedge clock);
            cyc++;
            if (prev_stalled && resetn) begin
                chk("kstart_held", {31'd0, k_start}, 32'd1);
                chk("kidx_held", k_idx, prev_idx);
            end
            if (pend_idx.size() >= MAX_OUT)
                chk("kstart_capped", {31'd0, k_start}, 32'd0);
            if (busy_arm && k_start && iss_log.size() == 1) begin
                busy_arm = 0;
                bk_cnt   = 5;
            end
            if (bk_cnt > 0) begin
                k_busy = 1'b1;
                bk_cnt--;
            end else begin
                k_busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            if (pend_idx.size() > 0 && pend_due[0] <= cyc) begin
                k_done       = 1'b1;
                k_returndata = pend_idx[0] << 1;
            end else begin
                k_done       = 1'b0;
                k_returndata = $urandom;
            end
            if (k_done && (!k_stall || stale_mode)) begin
                void'(pend_idx.pop_front());
                void'(pend_due.pop_front());
            end
            if (k_start && !k_busy) begin
                pend_idx.push_back(k_idx);
                pend_due.push_back(cyc + lat);
                iss_log.push_back(k_idx);
                iss_cyc.push_back(cyc);
            end
            if (pend_idx.size() > max_out_seen) max_out_seen = pend_idx.size();
            prev_stalled = k_start && k_busy;
            prev_idx     = k_idx;
        end
    end

    task automatic sweep(input logic [31:0] b, input logic [15:0] n, input int hold, input bit consec);
        logic [31:0] exp;
        int t;
        exp = 32'd0;
        for (int i = 0; i < int'(n); i++) exp += (b + 32'(i)) << 1;
        iss_log.delete();
        iss_cyc.delete();
        @(negedge clock);
        chk("idle_before_start", {31'd0, busy}, 32'd0);
        start = 1'b1;
        base  = b;
        count = n;
        stall = (hold > 0);
        @(negedge clock);
        start = 1'b0;
        base  = $urandom;
        count = 16'($urandom);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (n == 16'd0) chk("zero_count_latency", {31'd0, done}, 32'd1);
        t = 0;
        while (!done && t < 5000) begin
            start = 1'($urandom_range(0, 1));
            base  = $urandom;
            count = 16'($urandom);
            @(negedge clock);
            t++;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("result", returndata, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("done_held", {31'd0, done}, 32'd1);
            chk("result_held", returndata, exp);
        end
        stall = 1'b0;
        @(negedge clock);
        chk("done_cleared", {31'd0, done}, 32'd0);
        chk("idle_after", {31'd0, busy}, 32'd0);
        chk("rdata_zero_idle", returndata, 32'd0);
        chk("issue_count", 32'(iss_log.size()), {16'd0, n});
        for (int i = 0; i < iss_log.size(); i++) begin
            chk("issue_idx", iss_log[i], b + 32'(i));
            if (consec && i > 0) chk("issue_back_to_back", 32'(iss_cyc[i] - iss_cyc[i-1]), 32'd1);
        end
    endtask

    initial begin
        int t;
        resetn = 1'b0;
        start  = 1'b0;
        base   = 32'd0;
        count  = 16'd0;
        stall  = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdata", returndata, 32'd0);
        chk("rst_kstart", {31'd0, k_start}, 32'd0);
        chk("rst_kidx", k_idx, 32'd0);
        chk("rst_kstall", {31'd0, k_stall}, 32'd1);
        @(posedge clock);
        #1 resetn = 1'b1;

        sweep(32'd5, 16'd3, 0, 1);
        sweep(32'd77, 16'd0, 0, 0);
        sweep(32'hFFFF_FFFE, 16'd3, 0, 1);

        lat = 10;
        max_out_seen = 0;
        sweep(32'd1000, 16'd8, 0, 0);
        chk("max_outstanding", 32'(max_out_seen), 32'(MAX_OUT));

        lat = 3;
        busy_arm = 1;
        sweep(32'h40, 16'd4, 3, 0);

        // abandon a sweep with calls in flight
        lat = 10;
        iss_log.delete();
        @(negedge clock);
        start = 1'b1;
        base  = 32'd100;
        count = 16'd6;
        @(negedge clock);
        start = 1'b0;
        t = 0;
        while (pend_idx.size() < 2 && t < 100) begin
            @(negedge clock);
            t++;
        end
        chk("calls_in_flight", {31'd0, pend_idx.size() >= 2}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_rdata", returndata, 32'd0);
        chk("midrst_kstart", {31'd0, k_start}, 32'd0);
        chk("midrst_kidx", k_idx, 32'd0);
        chk("midrst_kstall", {31'd0, k_stall}, 32'd1);
        @(negedge clock);
        resetn = 1'b1;
        stale_mode = 1;
        t = 0;
        while (pend_idx.size() > 0 && t < 100) begin
            @(negedge clock);
            t++;
        end
        stale_mode = 0;
        chk("stale_drained", 32'(pend_idx.size()), 32'd0);
        chk("stale_ignored_busy", {31'd0, busy}, 32'd0);
        chk("stale_ignored_rdata", returndata, 32'd0);
        lat = 3;
        sweep(32'd1, 16'd1, 0, 0);

        rand_busy = 1;
        for (int r = 0; r < 8; r++) begin
            lat = $urandom_range(1, 8);
            sweep($urandom, 16'($urandom_range(0, 12)), $urandom_range(0, 2), 0);
        end
        rand_busy = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule

// File: doc/poly8_sweep.md
POLY8_SWEEP -- requirements
Module: poly8_sweep

Interface
REQ-001 Parameter MAX_OUT, default 4, SHALL set the maximum number of poly8 calls in flight (legal range 1..15).
REQ-002 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 resetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  in  1  SHALL be the host call valid; sampled only when busy=0.
REQ-005 busy  out  1  SHALL be the call stall to the host; high in every state except IDLE.
REQ-006 base  in  32  SHALL be the first idx of the sweep; latched on an accepted start.
REQ-007 count  in  16  SHALL be the number of idx values to sweep; latched on an accepted start.
REQ-008 done  out  1  SHALL be the return valid to the host.
REQ-009 stall  in  1  SHALL be the host return stall.
REQ-010 returndata  out  32  SHALL be the sweep result, meaningful while done=1.
REQ-011 k_start  out  1  SHALL be the call valid to the downstream poly8 component.
REQ-012 k_busy  in  1  SHALL be the poly8 call stall.
REQ-013 k_idx  out  32  SHALL be the idx data presented to poly8.
REQ-014 k_done  in  1  SHALL be the poly8 return valid.
REQ-015 k_stall  out  1  SHALL be the return stall to poly8.
REQ-016 k_returndata  in  32  SHALL be the poly8 return data.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, RESULT.
REQ-018 IDLE: start=1 accepted in one cycle; latch base, count; clear sum, issued, received, outstanding; next state RESULT if count=0, else RUN.
REQ-019 An issue SHALL occur in any cycle with k_start=1 and k_busy=0; k_start, k_idx held stable while k_busy=1.
REQ-020 k_start SHALL be 1 in RUN only when issued<count and outstanding<MAX_OUT; 0 in all other states.
REQ-021 k_idx SHALL equal base+issued modulo 2^32 (wraps past 0xFFFFFFFF to 0).
REQ-022 k_stall SHALL be 0 in RUN and DRAIN, 1 in IDLE and RESULT; a return is accepted when k_done=1 and k_stall=0.
REQ-023 Each accepted return SHALL add k_returndata to the 32-bit sum modulo 2^32, increment received, decrement outstanding.
REQ-024 Issue and accept in the same cycle SHALL leave outstanding unchanged; issued and received both update.
REQ-025 RUN -> DRAIN when issued reaches count (including the issuing cycle); DRAIN -> RESULT when received reaches count; RUN -> RESULT directly if both reach count in the same cycle.
REQ-026 RESULT: done=1, returndata=sum (final accepted value included); in a cycle with stall=0 the result is consumed and next state is IDLE; with stall=1 done and returndata held.
REQ-027 Latency: count=0 start accepted in cycle T -> done=1 in cycle T+1.
REQ-028 start while busy=1 SHALL be ignored; k_done while k_stall=1 SHALL be ignored (no sum change).
REQ-029 done=0 and returndata=0 in all states except RESULT.

Reset
REQ-030 resetn=0 SHALL immediately force IDLE, busy=0, done=0, returndata=0, k_start=0, k_idx=0, k_stall=1, and clear sum, issued, received, outstanding.
REQ-031 Reset mid-sweep SHALL abandon the sweep; returns from calls issued before reset are not counted.
REQ-032 First start SHALL be accepted in the first rising edge after resetn deasserts.

Verification (poly8 model: returns 2*idx, 3-cycle latency, unless stated)
REQ-033 base=5, count=3, stall=0 -> k_idx 5,6,7 issued on consecutive cycles; done=1 for one cycle with returndata=36.
REQ-034 count=0 -> no k_start; done=1 one cycle after start, returndata=0.
REQ-035 base=0xFFFFFFFE, count=3 -> k_idx 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; returndata=0xFFFFFFFA (sum wraps).
REQ-036 count=8, model latency 10, k_busy=0 -> k_start deasserts after 4 issues until first return; never more than 4 outstanding; returndata=2*(sum of idx).
REQ-037 k_busy=1 for 5 cycles on second issue, host stall=1 for 3 cycles in RESULT -> k_idx held during k_busy; done and returndata held 3 cycles; IDLE after stall drops.
REQ-038 resetn pulsed low while 2 calls outstanding -> all outputs at reset values that cycle; late k_done ignored; next sweep base=1, count=1 returns 2.
